wash_phase_timer: RTL and testbench
===================================

WASH_PHASE_TIMER -- requirements
Module: wash_phase_timer

Interface
REQ-001 Parameter FILL_CYCLES, default 20, clocks of fill_value_on needed to fill the drum.
REQ-002 Parameter WASH_CYCLES, default 50, agitation clocks when water_wash=0 (soap wash).
REQ-003 Parameter RINSE_CYCLES, default 30, agitation clocks when water_wash=1 (rinse).
REQ-004 Parameter DRAIN_CYCLES, default 15, clocks of drain_value_on needed to empty the drum.
REQ-005 Parameter SPIN_CYCLES, default 40, spin clocks; CNT_W, default 16, counter width; every *_CYCLES SHALL be in 1..2^CNT_W-1.
REQ-006 clk  input  1  sole clock, rising edge; reset is synchronous and active-high.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 fill_value_on, motor_on, drain_value_on  input  1 each  actuator commands from the washer controller.
REQ-009 water_wash  input  1  rinse-phase flag from the controller.
REQ-010 filled, cycle_timeout, drained, spin_timeout  output  1 each  registered single-cycle completion pulses.
REQ-011 fault  output  1  sticky flag: more than one actuator command high in the same cycle.

Function
REQ-012 The block SHALL use one FSM with states IDLE, FILL, AGITATE, DRAIN, SPIN, WAIT_OFF and one shared CNT_W-bit counter.
REQ-013 IDLE: priority drain_value_on > motor_on > fill_value_on; highest set command moves to DRAIN, AGITATE or FILL respectively, counter loaded 0.
REQ-014 At entry to AGITATE the limit SHALL latch RINSE_CYCLES if water_wash=1, else WASH_CYCLES; water_wash changes mid-phase SHALL be ignored.
REQ-015 In an active state with its command still high, each edge SHALL increment the counter; at the edge where counter == limit-1 the phase's pulse SHALL register high for exactly one cycle.
REQ-016 Latency: command first sampled high at edge k -> pulse high in the cycle after edge k+limit.
REQ-017 After a FILL or AGITATE pulse, and a DRAIN pulse with water_wash=0, the FSM SHALL enter WAIT_OFF and return to IDLE only once all three commands are low, so a held command never retriggers.
REQ-018 A DRAIN pulse with water_wash=1 SHALL go directly to SPIN with counter 0, spin timed while drain_value_on stays high; a SPIN pulse goes to WAIT_OFF.
REQ-019 If an active state's command drops before terminal count, the FSM SHALL return to IDLE, clear the counter and emit no pulse.
REQ-020 At most one output pulse SHALL be high in any cycle.
REQ-021 fault SHALL set on any edge sampling two or more commands high and stay set until reset; timing continues per REQ-013 priority.
REQ-022 Counter SHALL never wrap; it stops at terminal count.

Reset
REQ-023 On a rising clk edge with reset=1: state IDLE, counter 0, latched limit 0, all pulses 0, fault 0.
REQ-024 Reset mid-phase SHALL abort the phase without a pulse; reset dominates all other inputs on that edge.

Structure
REQ-025 A shared package SHALL hold the phase-state enumeration and the default cycle-count constants, for use by this block and the washer controller bench.
REQ-026 One sub-module, phase_counter (clear, enable, limit input, terminal-count output), is natural; the FSM and pulse registers stay in wash_phase_timer.

Verification (FILL=4, WASH=6, RINSE=3, DRAIN=2, SPIN=5)
REQ-027 fill_value_on high from edge 1 -> filled high only in the cycle after edge 5; command held to edge 9 -> no second pulse.
REQ-028 motor_on high at edge 1, water_wash=0 -> cycle_timeout after edge 7; repeat with water_wash=1 -> after edge 4.
REQ-029 drain_value_on high from edge 1 continuously, water_wash=1 -> drained after edge 3, spin_timeout after edge 8.
REQ-030 fill_value_on high edges 1-3 then low -> no filled pulse, state IDLE; restart at edge 6 -> filled after edge 10.
REQ-031 fill_value_on and motor_on both high at edge 1 -> fault=1 from edge 1 until reset, AGITATE timed, cycle_timeout after edge 7.
REQ-032 reset=1 at edge 3 of a FILL phase -> all outputs 0 after edge 3, no filled pulse unless re-armed.

Source files
------------

// File: rtl/wash_phase_timer_pkg.sv
// Shared definitions for the washer phase timer: FSM state codes, default
// phase lengths and a helper for detecting conflicting actuator commands.
package wash_phase_timer_pkg;

    typedef logic [2:0] phase_state_t;

    localparam phase_state_t ST_IDLE     = 3'd0;
    localparam phase_state_t ST_FILL     = 3'd1;
    localparam phase_state_t ST_AGITATE  = 3'd2;
    localparam phase_state_t ST_DRAIN    = 3'd3;
    localparam phase_state_t ST_SPIN     = 3'd4;
    localparam phase_state_t ST_WAIT_OFF = 3'd5;

    localparam int DEF_FILL_CYCLES  = 20;
    localparam int DEF_WASH_CYCLES  = 50;
    localparam int DEF_RINSE_CYCLES = 30;
    localparam int DEF_DRAIN_CYCLES = 15;
    localparam int DEF_SPIN_CYCLES  = 40;
    localparam int DEF_CNT_W        = 16;

    // True when two or more of the three actuator commands are asserted.
    function automatic logic multi_cmd(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/wash_phase_timer_if.sv
// Controller <-> phase timer bundle: actuator commands in one direction,
// completion pulses and the sticky fault flag in the other.
interface wash_phase_timer_if;
    logic fill_value_on;
    logic motor_on;
    logic drain_value_on;
    logic water_wash;
    logic filled;
    logic cycle_timeout;
    logic drained;
    logic spin_timeout;
    logic fault;

    modport master (
        output fill_value_on, motor_on, drain_value_on, water_wash,
        input  filled, cycle_timeout, drained, spin_timeout, fault
    );

    modport slave (
        input  fill_value_on, motor_on, drain_value_on, water_wash,
        output filled, cycle_timeout, drained, spin_timeout, fault
    );
endinterface

// File: rtl/wash_phase_timer_phase_counter.sv
// Shared phase counter: clears on request, counts while enabled and holds
// once it reaches limit-1 so it can never wrap.
module phase_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == (limit_i - CNT_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !tc_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wash_phase_timer.sv
// Washer phase timer: times fill, agitate, drain and spin phases against the
// controller's actuator commands and emits one-cycle completion pulses.
module wash_phase_timer
    import wash_phase_timer_pkg::*;
#(
    parameter int FILL_CYCLES  = DEF_FILL_CYCLES,
    parameter int WASH_CYCLES  = DEF_WASH_CYCLES,
    parameter int RINSE_CYCLES = DEF_RINSE_CYCLES,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int SPIN_CYCLES  = DEF_SPIN_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    wash_phase_timer_if.slave  bus
);

    phase_state_t     state_q, state_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic             cnt_clr, cnt_en, tc;
    logic             filled_q, filled_d;
    logic             cycle_timeout_q, cycle_timeout_d;
    logic             drained_q, drained_d;
    logic             spin_timeout_q, spin_timeout_d;
    logic             fault_q, fault_d;

    phase_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (cnt_clr),
        .enable_i (cnt_en),
        .limit_i  (limit_q),
        .tc_o     (tc)
    );

    always_comb begin
        state_d         = state_q;
        limit_d         = limit_q;
        cnt_clr         = 1'b0;
        cnt_en          = 1'b0;
        filled_d        = 1'b0;
        cycle_timeout_d = 1'b0;
        drained_d       = 1'b0;
        spin_timeout_d  = 1'b0;
        fault_d         = fault_q | multi_cmd(bus.fill_value_on, bus.motor_on, bus.drain_value_on);

        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (bus.drain_value_on) begin
                    state_d = ST_DRAIN;
                    limit_d = CNT_W'(DRAIN_CYCLES);
                end else if (bus.motor_on) begin
                    // Wash/rinse choice is frozen here; later water_wash changes are ignored.
                    state_d = ST_AGITATE;
                    limit_d = bus.water_wash ? CNT_W'(RINSE_CYCLES) : CNT_W'(WASH_CYCLES);
                end else if (bus.fill_value_on) begin
                    state_d = ST_FILL;
                    limit_d = CNT_W'(FILL_CYCLES);
                end
            end

            ST_FILL: begin
                if (!bus.fill_value_on) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (tc) begin
                    state_d  = ST_WAIT_OFF;
                    cnt_clr  = 1'b1;
                    filled_d = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_AGITATE: begin
                if (!bus.motor_on) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (tc) begin
                    state_d         = ST_WAIT_OFF;
                    cnt_clr         = 1'b1;
                    cycle_timeout_d = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_DRAIN: begin
                if (!bus.drain_value_on) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (tc) begin
                    cnt_clr   = 1'b1;
                    drained_d = 1'b1;
                    // Final rinse drain rolls straight into spin on the same drain command.
                    if (bus.water_wash) begin
                        state_d = ST_SPIN;
                        limit_d = CNT_W'(SPIN_CYCLES);
                    end else begin
                        state_d = ST_WAIT_OFF;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_SPIN: begin
                if (!bus.drain_value_on) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (tc) begin
                    state_d        = ST_WAIT_OFF;
                    cnt_clr        = 1'b1;
                    spin_timeout_d = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_WAIT_OFF: begin
                cnt_clr = 1'b1;
                if (!bus.fill_value_on && !bus.motor_on && !bus.drain_value_on) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            limit_q         <= '0;
            filled_q        <= 1'b0;
            cycle_timeout_q <= 1'b0;
            drained_q       <= 1'b0;
            spin_timeout_q  <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            limit_q         <= limit_d;
            filled_q        <= filled_d;
            cycle_timeout_q <= cycle_timeout_d;
            drained_q       <= drained_d;
            spin_timeout_q  <= spin_timeout_d;
            fault_q         <= fault_d;
        end
    end

    assign bus.filled        = filled_q;
    assign bus.cycle_timeout = cycle_timeout_q;
    assign bus.drained       = drained_q;
    assign bus.spin_timeout  = spin_timeout_q;
    assign bus.fault         = fault_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Scoreboard bench for wash_phase_timer with short phase lengths
// (FILL=4, WASH=6, RINSE=3, DRAIN=2, SPIN=5).
module tb_wash_phase_timer;

    localparam logic [3:0] K_FILLED  = 4'b0001;
    localparam logic [3:0] K_CTO     = 4'b0010;
    localparam logic [3:0] K_DRAINED = 4'b0100;
    localparam logic [3:0] K_SPIN    = 4'b1000;

    typedef struct {
        logic [3:0] kind;
        int         edge_n;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   base = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t expq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wash_phase_timer_if bus();

    wash_phase_timer #(
        .FILL_CYCLES  (4),
        .WASH_CYCLES  (6),
        .RINSE_CYCLES (3),
        .DRAIN_CYCLES (2),
        .SPIN_CYCLES  (5),
        .CNT_W        (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [3:0] pulses;
    logic [4:0] outs;
    assign pulses = {bus.spin_timeout, bus.drained, bus.cycle_timeout, bus.filled};
    assign outs   = {bus.filled, bus.cycle_timeout, bus.drained, bus.spin_timeout, bus.fault};

    // Monitor: every pulse the DUT shows must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if ((|pulses) === 1'b1) begin
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: got pulses=%b after edge %0d, required none", pulses, cyc);
            end else begin
                e = expq.pop_front();
                if (pulses !== e.kind || cyc != e.edge_n) begin
                    fails++;
                    $display("FAIL %s: got pulses=%b after edge %0d, required %b after edge %0d",
                             e.name, pulses, cyc, e.kind, e.edge_n);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic f, input logic m, input logic d, input logic w);
        bus.fill_value_on  = f;
        bus.motor_on       = m;
        bus.drain_value_on = d;
        bus.water_wash     = w;
    endtask

    task automatic expect_pulse(input logic [3:0] k, input int rel, input string name);
        exp_t e;
        e.kind   = k;
        e.edge_n = base + rel;
        e.name   = name;
        expq.push_back(e);
    endtask

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic check_queue(input string name);
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL %s: got %0d expected pulses missing, required 0", name, expq.size());
            expq.delete();
        end
    endtask

    task automatic do_reset(input string name);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check(name, outs, 5'b0);
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step(1);

        // Fill held past completion: one pulse only.
        do_reset("reset_initial");
        base = cyc;
        expect_pulse(K_FILLED, 5, "fill_basic");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step(9);
        check("fill_no_fault", {4'b0, bus.fault}, 5'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        check_queue("fill_basic_done");

        // Soap wash, water_wash toggled mid-phase must be ignored.
        base = cyc;
        expect_pulse(K_CTO, 7, "wash_soap");
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        step(2);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        step(6);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        check_queue("wash_soap_done");

        // Rinse agitation.
        base = cyc;
        expect_pulse(K_CTO, 4, "wash_rinse");
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        step(6);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        check_queue("wash_rinse_done");

        // Rinse drain flows into spin.
        base = cyc;
        expect_pulse(K_DRAINED, 3, "drain_rinse");
        expect_pulse(K_SPIN, 8, "spin");
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        step(10);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        check_queue("drain_spin_done");

        // Soap drain: no spin afterwards.
        base = cyc;
        expect_pulse(K_DRAINED, 3, "drain_soap");
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        step(10);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        check_queue("drain_soap_done");

        // Aborted fill, then restart at edge 6.
        base = cyc;
        expect_pulse(K_FILLED, 10, "fill_restart");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step(3);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step(6);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        check_queue("fill_restart_done");

        // Conflicting commands: fault sticks, agitation still timed.
        do_reset("reset_before_fault");
        base = cyc;
        expect_pulse(K_CTO, 7, "fault_agitate");
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        step(1);
        check("fault_set_edge1", {4'b0, bus.fault}, 5'b00001);
        step(7);
        check("fault_held_edge8", {4'b0, bus.fault}, 5'b00001);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        check("fault_sticky_idle", {4'b0, bus.fault}, 5'b00001);
        check_queue("fault_agitate_done");
        do_reset("reset_clears_fault");

        // Reset at edge 3 of a fill aborts it; fill re-arms from edge 4.
        base = cyc;
        expect_pulse(K_FILLED, 8, "fill_after_reset");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step(2);
        reset = 1'b1;
        step(1);
        check("reset_mid_fill", outs, 5'b0);
        reset = 1'b0;
        step(6);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        check_queue("fill_after_reset_done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
